// File: rtl/hls_ap_ctrl_driver.sv
// hls_ap_ctrl_driver
// Initiator side of the ap_ctrl_hs block-level handshake for the generated macc kernels.
// Takes one job at a time from the host request port and pulses kern_ap_start until the
// kernel acknowledges it. While the job runs it captures the kernel's vld-qualified outputs,
// and it returns them with status on the response port.
// A watchdog aborts a kernel that never signals ap_done. It then pulses kern_ap_rst and
// reports a timeout.
//
// Ports
//   ap_clk, ap_rst_n         clock, synchronous active-low reset
//   req_valid/req_ready      host job request; req_out30_init seeds the out30 in/out operand
//   rsp_valid/rsp_ready      response handshake
//   rsp_out13/30/31          captured kernel outputs (rsp_out30 defaults to the seed)
//   rsp_vld_mask             bit0 out13, bit1 out30, bit2 out31 seen this job
//   rsp_timeout              job aborted by the watchdog
//   rsp_latency              ap_start rise to ap_done in cycles, saturating
//   jobs_done                completed (non-timeout) jobs, wraps
//   kern_*                   ap_ctrl_hs kernel interface and data
// All outputs are registered.
module hls_ap_ctrl_driver #(
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned RST_CYCLES     = 4,
  parameter int unsigned LAT_W          = 16
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DW-1:0]    req_out30_init,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_out13,
  output logic [DW-1:0]    rsp_out30,
  output logic [DW-1:0]    rsp_out31,
  output logic [2:0]       rsp_vld_mask,
  output logic             rsp_timeout,
  output logic [LAT_W-1:0] rsp_latency,
  output logic [15:0]      jobs_done,
  output logic             kern_ap_start,
  output logic             kern_ap_rst,
  input  logic             kern_ap_done,
  input  logic             kern_ap_idle,
  input  logic             kern_ap_ready,
  input  logic [DW-1:0]    kern_out13,
  input  logic             kern_out13_vld,
  output logic [DW-1:0]    kern_out30_i,
  input  logic [DW-1:0]    kern_out30_o,
  input  logic             kern_out30_vld,
  input  logic [DW-1:0]    kern_out31,
  input  logic             kern_out31_vld
);

  typedef enum logic [2:0] {StIdle, StRun, StWait, StKrst, StResp} state_e;

  // The watchdog fires on the edge where the count would reach TIMEOUT_CYCLES.
  localparam logic [15:0]      TmoLast = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       RstLast = 8'(RST_CYCLES - 1);
  localparam logic [LAT_W-1:0] LatMax  = '1;
  localparam logic [LAT_W-1:0] LatOne  = LAT_W'(1);

  state_e           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    out13_q, out13_d;
  logic [DW-1:0]    out30_q, out30_d;
  logic [DW-1:0]    out31_q, out31_d;
  logic [2:0]       mask_q, mask_d;
  logic             timeout_q, timeout_d;
  logic [LAT_W-1:0] rsp_lat_q, rsp_lat_d;
  logic [15:0]      jobs_q, jobs_d;
  logic             start_q, start_d;
  logic             krst_q, krst_d;
  logic [DW-1:0]    out30_i_q, out30_i_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [7:0]       rst_cnt_q, rst_cnt_d;
  logic [LAT_W-1:0] lat_inc;

  // ap_idle is informational only; the handshake relies on ap_ready/ap_done.
  logic unused_idle;
  assign unused_idle = kern_ap_idle;

  always_comb begin
    state_d   = state_q;
    rsp_valid_d = rsp_valid_q;
    out13_d   = out13_q;
    out30_d   = out30_q;
    out31_d   = out31_q;
    mask_d    = mask_q;
    timeout_d = timeout_q;
    rsp_lat_d = rsp_lat_q;
    jobs_d    = jobs_q;
    start_d   = start_q;
    krst_d    = krst_q;
    out30_i_d = out30_i_q;
    lat_d     = lat_q;
    tmo_d     = tmo_q;
    rst_cnt_d = rst_cnt_q;
    lat_inc   = (lat_q == LatMax) ? lat_q : lat_q + LatOne;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          out30_i_d = req_out30_init;
          out30_d   = req_out30_init;
          mask_d    = 3'b000;
          lat_d     = '0;
          tmo_d     = '0;
          start_d   = 1'b1;
          state_d   = StRun;
        end
      end

      StRun, StWait: begin
        lat_d = lat_inc;
        tmo_d = tmo_q + 16'd1;
        if (kern_out13_vld) begin
          out13_d   = kern_out13;
          mask_d[0] = 1'b1;
        end
        if (kern_out30_vld) begin
          out30_d   = kern_out30_o;
          mask_d[1] = 1'b1;
        end
        if (kern_out31_vld) begin
          out31_d   = kern_out31;
          mask_d[2] = 1'b1;
        end
        // Priority: completion beats the watchdog, which beats a bare ap_ready.
        if (kern_ap_done) begin
          start_d     = 1'b0;
          rsp_lat_d   = lat_inc;
          jobs_d      = jobs_q + 16'd1;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else if (tmo_q == TmoLast) begin
          start_d   = 1'b0;
          timeout_d = 1'b1;
          rsp_lat_d = lat_inc;
          krst_d    = 1'b1;
          rst_cnt_d = '0;
          state_d   = StKrst;
        end else if (state_q == StRun && kern_ap_ready) begin
          start_d = 1'b0;
          state_d = StWait;
        end
      end

      StKrst: begin
        rst_cnt_d = rst_cnt_q + 8'd1;
        if (rst_cnt_q == RstLast) begin
          krst_d      = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end
      end

      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          timeout_d   = 1'b0;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q     <= StIdle;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      out13_q     <= '0;
      out30_q     <= '0;
      out31_q     <= '0;
      mask_q      <= '0;
      timeout_q   <= 1'b0;
      rsp_lat_q   <= '0;
      jobs_q      <= '0;
      start_q     <= 1'b0;
      krst_q      <= 1'b0;
      out30_i_q   <= '0;
      lat_q       <= '0;
      tmo_q       <= '0;
      rst_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      out13_q     <= out13_d;
      out30_q     <= out30_d;
      out31_q     <= out31_d;
      mask_q      <= mask_d;
      timeout_q   <= timeout_d;
      rsp_lat_q   <= rsp_lat_d;
      jobs_q      <= jobs_d;
      start_q     <= start_d;
      krst_q      <= krst_d;
      out30_i_q   <= out30_i_d;
      lat_q       <= lat_d;
      tmo_q       <= tmo_d;
      rst_cnt_q   <= rst_cnt_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_out13     = out13_q;
  assign rsp_out30     = out30_q;
  assign rsp_out31     = out31_q;
  assign rsp_vld_mask  = mask_q;
  assign rsp_timeout   = timeout_q;
  assign rsp_latency   = rsp_lat_q;
  assign jobs_done     = jobs_q;
  assign kern_ap_start = start_q;
  assign kern_ap_rst   = krst_q;
  assign kern_out30_i  = out30_i_q;

endmodule

// File: tb/tb_hls_ap_ctrl_driver.sv
// Self-checking bench for hls_ap_ctrl_driver: directed handshake scenarios plus randomized
// jobs, checked against a job-level reference model (last-write-wins capture, latency equal
// to the done cycle, watchdog at TMO cycles).
module tb_hls_ap_ctrl_driver;
  localparam int DW   = 32;
  localparam int TMO  = 16;
  localparam int RSTC = 4;
  localparam int LW   = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] req_out30_init = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_out13, rsp_out30, rsp_out31;
  logic [2:0]    rsp_vld_mask;
  logic          rsp_timeout;
  logic [LW-1:0] rsp_latency;
  logic [15:0]   jobs_done;
  logic          kern_ap_start, kern_ap_rst;
  logic          kern_ap_done = 1'b0, kern_ap_idle = 1'b1, kern_ap_ready = 1'b0;
  logic [DW-1:0] kern_out13 = '0, kern_out30_o = '0, kern_out31 = '0;
  logic          kern_out13_vld = 1'b0, kern_out30_vld = 1'b0, kern_out31_vld = 1'b0;
  logic [DW-1:0] kern_out30_i;

  hls_ap_ctrl_driver #(
    .DW(DW), .TIMEOUT_CYCLES(TMO), .RST_CYCLES(RSTC), .LAT_W(LW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_out30_init(req_out30_init),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out13(rsp_out13), .rsp_out30(rsp_out30), .rsp_out31(rsp_out31),
    .rsp_vld_mask(rsp_vld_mask), .rsp_timeout(rsp_timeout), .rsp_latency(rsp_latency),
    .jobs_done(jobs_done),
    .kern_ap_start(kern_ap_start), .kern_ap_rst(kern_ap_rst),
    .kern_ap_done(kern_ap_done), .kern_ap_idle(kern_ap_idle), .kern_ap_ready(kern_ap_ready),
    .kern_out13(kern_out13), .kern_out13_vld(kern_out13_vld),
    .kern_out30_i(kern_out30_i), .kern_out30_o(kern_out30_o), .kern_out30_vld(kern_out30_vld),
    .kern_out31(kern_out31), .kern_out31_vld(kern_out31_vld)
  );

  always #5 ap_clk = ~ap_clk;

  int errors = 0;
  int checks = 0;

  // Per-cycle kernel output stimulus for the current job (index = cycle after acceptance).
  logic          st_v13 [0:TMO];
  logic          st_v30 [0:TMO];
  logic          st_v31 [0:TMO];
  logic [DW-1:0] st_d13 [0:TMO];
  logic [DW-1:0] st_d30 [0:TMO];
  logic [DW-1:0] st_d31 [0:TMO];

  // Reference model state that persists across jobs.
  logic [DW-1:0] m13 = '0, m31 = '0;
  logic [15:0]   m_jobs = '0;

  task automatic clear_stim();
    for (int k = 0; k <= TMO; k++) begin
      st_v13[k] = 1'b0; st_v30[k] = 1'b0; st_v31[k] = 1'b0;
      st_d13[k] = '0;   st_d30[k] = '0;   st_d31[k] = '0;
    end
  endtask

  task automatic idle_kernel();
    kern_ap_done = 1'b0; kern_ap_ready = 1'b0;
    kern_out13_vld = 1'b0; kern_out30_vld = 1'b0; kern_out31_vld = 1'b0;
  endtask

  // rdy/dn: cycle of ap_ready / ap_done (0 = never). hold: cycles rsp_ready stays low.
  // req_hold: keep a new request (next_init) pending while the response is held.
  task automatic run_job(input string tag, input logic [DW-1:0] init, input int rdy,
                         input int dn, input int hold, input bit req_hold,
                         input logic [DW-1:0] next_init);
    int            endc, starts, rsts, waitc, exp_starts;
    bit            tmo;
    logic [DW-1:0] e13, e30, e31;
    logic [2:0]    emask;
    logic [15:0]   ejobs;

    // Reference: last valid write within the job's live window wins.
    tmo   = (dn == 0);
    endc  = tmo ? TMO : dn;
    e13   = m13; e30 = init; e31 = m31; emask = 3'b000;
    for (int k = 1; k <= endc; k++) begin
      if (st_v13[k]) begin e13 = st_d13[k]; emask[0] = 1'b1; end
      if (st_v30[k]) begin e30 = st_d30[k]; emask[1] = 1'b1; end
      if (st_v31[k]) begin e31 = st_d31[k]; emask[2] = 1'b1; end
    end
    exp_starts = (rdy != 0 && rdy < endc) ? rdy : endc;
    ejobs = tmo ? m_jobs : m_jobs + 16'd1;

    waitc = 0;
    while (!req_ready && waitc < 20) begin @(posedge ap_clk); #1; waitc++; end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1; req_out30_init = init;
    @(posedge ap_clk); #1;
    req_valid = 1'b0; req_out30_init = $urandom;

    starts = 0; rsts = 0;
    for (int k = 1; k <= endc; k++) begin
      kern_ap_ready  = (k == rdy);
      kern_ap_done   = (k == dn);
      kern_out13_vld = st_v13[k]; kern_out13   = st_d13[k];
      kern_out30_vld = st_v30[k]; kern_out30_o = st_d30[k];
      kern_out31_vld = st_v31[k]; kern_out31   = st_d31[k];
      if (kern_ap_start) starts++;
      if (kern_ap_rst) rsts++;
      if (k == 1) begin
        checks++;
        if (kern_out30_i !== init) begin
          errors++; $display("FAIL %s out30_i: got %h want %h", tag, kern_out30_i, init);
        end
      end
      @(posedge ap_clk); #1;
    end

    // Garbage on the kernel side while no job is live must be ignored.
    waitc = 0;
    while (!rsp_valid && waitc < RSTC + 10) begin
      kern_ap_done = 1'($urandom); kern_ap_ready = 1'($urandom);
      kern_out13_vld = 1'($urandom); kern_out13 = $urandom;
      kern_out30_vld = 1'($urandom); kern_out30_o = $urandom;
      kern_out31_vld = 1'($urandom); kern_out31 = $urandom;
      if (kern_ap_start) starts++;
      if (kern_ap_rst) rsts++;
      @(posedge ap_clk); #1;
      waitc++;
    end
    idle_kernel();

    checks++;
    if (waitc !== (tmo ? RSTC : 0)) begin
      errors++; $display("FAIL %s rsp_delay: got %0d want %0d", tag, waitc, tmo ? RSTC : 0);
    end
    checks++;
    if (starts !== exp_starts) begin
      errors++; $display("FAIL %s start_cycles: got %0d want %0d", tag, starts, exp_starts);
    end
    checks++;
    if (rsts !== (tmo ? RSTC : 0)) begin
      errors++; $display("FAIL %s ap_rst_cycles: got %0d want %0d", tag, rsts, tmo ? RSTC : 0);
    end
    checks++;
    if (rsp_out13 !== e13) begin
      errors++; $display("FAIL %s out13: got %h want %h", tag, rsp_out13, e13);
    end
    checks++;
    if (rsp_out30 !== e30) begin
      errors++; $display("FAIL %s out30: got %h want %h", tag, rsp_out30, e30);
    end
    checks++;
    if (rsp_out31 !== e31) begin
      errors++; $display("FAIL %s out31: got %h want %h", tag, rsp_out31, e31);
    end
    checks++;
    if (rsp_vld_mask !== emask) begin
      errors++; $display("FAIL %s mask: got %b want %b", tag, rsp_vld_mask, emask);
    end
    checks++;
    if (rsp_timeout !== tmo) begin
      errors++; $display("FAIL %s timeout: got %b want %b", tag, rsp_timeout, tmo);
    end
    if (!tmo) begin
      checks++;
      if (rsp_latency !== LW'(dn)) begin
        errors++; $display("FAIL %s latency: got %0d want %0d", tag, rsp_latency, dn);
      end
    end
    checks++;
    if (jobs_done !== ejobs) begin
      errors++; $display("FAIL %s jobs_done: got %0d want %0d", tag, jobs_done, ejobs);
    end
    m13 = e13; m31 = e31; m_jobs = ejobs;

    if (req_hold) begin req_valid = 1'b1; req_out30_init = next_init; end
    for (int h = 0; h < hold; h++) begin
      @(posedge ap_clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || kern_ap_start !== 1'b0 ||
          rsp_out13 !== e13 || rsp_out30 !== e30 || rsp_out31 !== e31 ||
          rsp_vld_mask !== emask || rsp_timeout !== tmo) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b ready=%b start=%b o13=%h o30=%h o31=%h mask=%b",
                 tag, h, rsp_valid, req_ready, kern_ap_start, rsp_out13, rsp_out30,
                 rsp_out31, rsp_vld_mask);
      end
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL %s req_ready_in_resp: got %b want 0", tag, req_ready);
    end
    rsp_ready = 1'b1;
    @(posedge ap_clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: valid=%b timeout=%b ready=%b want 0/0/1", tag, rsp_valid,
               rsp_timeout, req_ready);
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_out13, rsp_out30, rsp_out31, rsp_vld_mask, rsp_timeout,
         rsp_latency, jobs_done, kern_ap_start, kern_ap_rst, kern_out30_i} !== '0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b start=%b rst=%b jobs=%0d o30i=%h",
               req_ready, rsp_valid, kern_ap_start, kern_ap_rst, jobs_done, kern_out30_i);
    end
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_nominal();
    clear_stim();
    st_v13[4] = 1'b1; st_d13[4] = 32'h11;
    st_v30[4] = 1'b1; st_d30[4] = 32'h22;
    st_v31[4] = 1'b1; st_d31[4] = 32'h33;
    run_job("nominal", 32'h5, 4, 4, 0, 1'b0, '0);
  endtask

  task automatic test_ready_early();
    clear_stim();
    st_v13[2] = 1'b1; st_d13[2] = 32'hCAFE;
    run_job("ready_early", 32'h77, 2, 4, 0, 1'b0, '0);
  endtask

  task automatic test_partial();
    clear_stim();
    st_v31[1] = 1'b1; st_d31[1] = 32'hA;
    st_v31[3] = 1'b1; st_d31[3] = 32'hB;
    run_job("partial", 32'h1234, 4, 4, 0, 1'b0, '0);
  endtask

  task automatic test_hang();
    clear_stim();
    st_v30[3] = 1'b1; st_d30[3] = 32'hDEAD;
    run_job("hang", 32'h9, 0, 0, 0, 1'b0, '0);
  endtask

  task automatic test_done_at_expiry();
    clear_stim();
    st_v13[TMO] = 1'b1; st_d13[TMO] = 32'hE0E0;
    run_job("done_at_expiry", 32'h3, TMO, TMO, 0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    clear_stim();
    st_v30[2] = 1'b1; st_d30[2] = 32'h55;
    run_job("backpressure", 32'h100, 3, 3, 10, 1'b1, 32'h200);
    clear_stim();
    st_v13[1] = 1'b1; st_d13[1] = 32'h66;
    run_job("second_job", 32'h200, 4, 4, 0, 1'b0, '0);
  endtask

  task automatic test_reset_mid();
    int bad;
    req_valid = 1'b1; req_out30_init = 32'hABCD;
    @(posedge ap_clk); #1;
    req_valid = 1'b0;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b0;
    @(posedge ap_clk); #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_out13, rsp_out30, rsp_out31, rsp_vld_mask, rsp_timeout,
         rsp_latency, jobs_done, kern_ap_start, kern_ap_rst, kern_out30_i} !== '0) begin
      errors++;
      $display("FAIL reset_mid_values: ready=%b valid=%b start=%b rst=%b jobs=%0d o30i=%h",
               req_ready, rsp_valid, kern_ap_start, kern_ap_rst, jobs_done, kern_out30_i);
    end
    ap_rst_n = 1'b1;
    m13 = '0; m31 = '0; m_jobs = '0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge ap_clk); #1;
      if (rsp_valid !== 1'b0 || kern_ap_start !== 1'b0 || kern_ap_rst !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_mid_quiet: got %0d bad cycles want 0", bad);
    end
    test_nominal();
  endtask

  task automatic test_random();
    int            rdy, dn, endc, hold;
    logic [DW-1:0] init;
    for (int j = 0; j < 30; j++) begin
      clear_stim();
      if ($urandom_range(0, 5) == 0) begin
        dn  = 0;
        rdy = ($urandom_range(0, 1) == 1) ? $urandom_range(1, TMO) : 0;
      end else begin
        dn  = $urandom_range(1, TMO);
        rdy = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, dn);
      end
      endc = (dn == 0) ? TMO : dn;
      for (int k = 1; k <= endc; k++) begin
        st_v13[k] = ($urandom_range(0, 3) == 0); st_d13[k] = $urandom;
        st_v30[k] = ($urandom_range(0, 3) == 0); st_d30[k] = $urandom;
        st_v31[k] = ($urandom_range(0, 3) == 0); st_d31[k] = $urandom;
      end
      init = $urandom;
      hold = $urandom_range(0, 3);
      run_job("random", init, rdy, dn, hold, 1'b0, '0);
    end
  endtask

  initial begin
    clear_stim();
    test_reset();
    test_nominal();
    test_ready_early();
    test_partial();
    test_hang();
    test_done_at_expiry();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hls_ap_ctrl_driver.md
Name: hls_ap_ctrl_driver

Overview:
- Initiator side of the ap_ctrl_hs block-level handshake used by the generated macc kernels.
- Accepts one job at a time from a host valid/ready port and drives ap_start to the kernel.
- Captures the kernel's ap_vld-qualified outputs (out13, out30 in/out pair, out31) and returns them with status on a response valid/ready port.
- A watchdog detects a kernel that never completes (e.g. wrong locking_key), resets the kernel and reports a timeout.

Parameters:
- DW, 32, data width of each kernel output word.
- TIMEOUT_CYCLES, 1024, cycles after ap_start assertion before a job is declared hung (legal range 2..65535).
- RST_CYCLES, 4, length of the kernel reset pulse after a timeout (legal range 1..255).
- LAT_W, 16, width of the latency counter.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  host job request.
- req_ready  out  1  driver can accept a job.
- req_out30_init  in  DW  initial value for the kernel out30_i.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host accepts response.
- rsp_out13  out  DW  captured out13.
- rsp_out30  out  DW  captured out30_o, or out30_init if not written.
- rsp_out31  out  DW  captured out31.
- rsp_vld_mask  out  3  bit0 out13, bit1 out30, bit2 out31 seen valid this job.
- rsp_timeout  out  1  job aborted by watchdog.
- rsp_latency  out  LAT_W  cycles from ap_start rise to ap_done, saturating.
- jobs_done  out  16  completed-job counter, wraps; timeouts excluded.
- kern_ap_start  out  1  to kernel ap_start.
- kern_ap_rst  out  1  to kernel ap_rst (active-high).
- kern_ap_done  in  1  from kernel.
- kern_ap_idle  in  1  from kernel.
- kern_ap_ready  in  1  from kernel.
- kern_out13  in  DW  kernel output.
- kern_out13_vld  in  1  valid for kern_out13.
- kern_out30_i  out  DW  kernel in/out operand input.
- kern_out30_o  in  DW  kernel in/out operand output.
- kern_out30_vld  in  1  valid for kern_out30_o.
- kern_out31  in  DW  kernel output.
- kern_out31_vld  in  1  valid for kern_out31.

Behaviour:
- Clock and reset: one clock, ap_clk. Reset is synchronous, active-low (ap_rst_n sampled at the rising edge of ap_clk).
- Reset values:
  - state IDLE, req_ready=0 during reset, then 1.
  - rsp_valid=0, kern_ap_start=0, kern_ap_rst=0.
  - All rsp_* fields, jobs_done, kern_out30_i and the counters = 0.
- Reset mid-job: abandons the job without a response. kern_ap_rst is not pulsed; the system reset also resets the kernel.
- Every output is registered.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch req_out30_init into kern_out30_i and rsp_out30, clear the mask, clear the latency and timeout counters, then go to RUN.
  - kern_ap_start=1 from the next cycle.
- RUN (kern_ap_start=1):
  - Every cycle, the latency counter increments (saturates at 2^LAT_W-1) and the timeout counter increments.
  - Any cycle kern_outN_vld=1: the matching rsp_outN is loaded and its mask bit is set. A later vld overwrites (last write wins).
  - kern_ap_ready=1: kern_ap_start=0 from the next cycle. Go to WAIT if ap_done is not also high.
  - kern_ap_done=1 (with or without ap_ready in the same cycle): capture any simultaneous vld data, drop kern_ap_start, freeze rsp_latency, jobs_done+1, go to RESP.
- WAIT (kern_ap_start=0):
  - Same capture and counters as RUN.
  - On kern_ap_done: go to RESP with the same actions as above.
- Timeout: the timeout counter reaching TIMEOUT_CYCLES in RUN/WAIT without ap_done in that cycle:
  - kern_ap_start=0, rsp_timeout=1, go to KRST.
  - ap_done in the same cycle as expiry wins: normal completion.
- KRST:
  - kern_ap_rst=1 for exactly RST_CYCLES cycles, then go to RESP.
  - Captured fields and the mask keep whatever was received before the abort; vld inputs are ignored in KRST.
- RESP:
  - rsp_valid=1, fields stable.
  - On rsp_ready: rsp_valid=0 next cycle, rsp_timeout cleared, go to IDLE.
  - req_ready is 0 in all states except IDLE, so no new job is accepted in the cycle of response acceptance.
- Kernel ap_done outside RUN/WAIT is ignored. kern_ap_idle is status only and not used for control.
- Minimum job turnaround for a 4-state kernel: accept (1) + kernel states (4) + RESP (1) = 6 cycles with rsp_ready tied high.

Test Plan:
- Nominal job: req_out30_init=0x5; kernel raises ready/done/all three vlds together 4 cycles after start, out13=0x11, out30=0x22, out31=0x33 -> rsp 0x11/0x22/0x33, mask=3'b111, timeout=0, latency=4, jobs_done=1, kern_ap_start high exactly 4 cycles.
- ap_ready 2 cycles before ap_done, out13_vld in the ready cycle -> ap_start low after ready, driver waits in WAIT, response on done, mask bit0 set.
- out30 never written, out31_vld twice (0xA then 0xB) -> rsp_out30=req_out30_init, rsp_out31=0xB, mask=3'b100.
- Hung kernel (locking_key wrong, no done), TIMEOUT_CYCLES=16, RST_CYCLES=4 -> ap_start low at cycle 16, kern_ap_rst high exactly 4 cycles, rsp_timeout=1, jobs_done unchanged.
- rsp_ready held low 10 cycles with req_valid=1 -> rsp fields stable, req_ready=0 until 1 cycle after acceptance, then second job accepted.
- ap_rst_n asserted for 1 cycle mid-RUN -> all outputs return to reset values next cycle, no response emitted, next job behaves nominally.
